// File: rtl/spi_slave_module.sv
// SPI mode-0 slave register block, oversampled by clk: a command byte followed by
// a 32-bit config register access or a continuous 16-bit word stream from a sample buffer.
module spi_slave_module #(
    parameter logic [7:0]  ID     = 8'hA5,
    parameter logic [15:0] STATUS = 16'h5A01,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck_spi,
    input  logic              mosi_spi,
    input  logic              ncs_spi,
    output logic              miso_spi,
    output logic [7:0]        q_c,
    output logic [31:0]       adc_cfg_out,
    output logic [31:0]       dds_a_cfg_out,
    output logic [31:0]       dds_b_cfg_out,
    input  logic [15:0]       mem_data,
    output logic [ADDR_W-1:0] mem_addr
);

    typedef enum logic [1:0] {IDLE, CMD, CFG, MEM} state_t;

    state_t      state;
    logic [2:0]  sck_sr;
    logic [2:0]  ncs_sr;
    logic [1:0]  mosi_sr;
    logic [31:0] tx;
    logic [30:0] rx;
    logic [5:0]  bit_cnt;
    logic        addr_inc;

    logic        mosi_s;
    logic        sck_rise;
    logic        sck_fall;
    logic        ncs_rise;
    logic        ncs_fall;
    logic [7:0]  cmd_next;
    logic [31:0] rx_word_next;
    logic [31:0] rd_word;
    logic        wr_en;

    // Stage [1] is the synchronised level, stage [2] its previous value for edge detection.
    // Clearing ncs to 0 on reset means a frame already in progress cannot look like a new ncs fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sr  <= '0;
            ncs_sr  <= '0;
            mosi_sr <= '0;
        end else begin
            sck_sr  <= {sck_sr[1:0], sck_spi};
            ncs_sr  <= {ncs_sr[1:0], ncs_spi};
            mosi_sr <= {mosi_sr[0], mosi_spi};
        end
    end

    always_comb begin
        mosi_s       = mosi_sr[1];
        sck_rise     = sck_sr[1] & ~sck_sr[2];
        sck_fall     = ~sck_sr[1] & sck_sr[2];
        ncs_rise     = ncs_sr[1] & ~ncs_sr[2];
        ncs_fall     = ~ncs_sr[1] & ncs_sr[2];
        cmd_next     = {rx[6:0], mosi_s};
        rx_word_next = {rx[30:0], mosi_s};
    end

    always_comb begin
        rd_word = '0;
        case (cmd_next[6:0])
            7'd0:    rd_word = adc_cfg_out;
            7'd2:    rd_word = dds_a_cfg_out;
            7'd3:    rd_word = dds_b_cfg_out;
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        wr_en = q_c[7] && ((q_c[6:0] == 7'd0) || (q_c[6:0] == 7'd2) || (q_c[6:0] == 7'd3));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            miso_spi      <= 1'b0;
            tx            <= '0;
            rx            <= '0;
            bit_cnt       <= '0;
            addr_inc      <= 1'b0;
            q_c           <= '0;
            adc_cfg_out   <= '0;
            dds_a_cfg_out <= '0;
            dds_b_cfg_out <= '0;
            mem_addr      <= '0;
        end else begin
            addr_inc <= 1'b0;
            if (addr_inc) begin
                mem_addr <= mem_addr + 1'b1;
            end

            case (state)
                IDLE: begin
                    miso_spi <= 1'b0;
                    if (ncs_fall) begin
                        // tx holds the bits still to be sent; the ID MSB goes straight to miso
                        tx       <= {ID[6:0], 25'b0};
                        miso_spi <= ID[7];
                        bit_cnt  <= '0;
                        state    <= CMD;
                    end
                end

                default: begin
                    if (ncs_rise) begin
                        state    <= IDLE;
                        miso_spi <= 1'b0;
                    end else begin
                        if (sck_fall) begin
                            miso_spi <= tx[31];
                            tx       <= {tx[30:0], 1'b0};
                        end

                        if (sck_rise) begin
                            case (state)
                                CMD: begin
                                    rx      <= rx_word_next[30:0];
                                    bit_cnt <= bit_cnt + 6'd1;
                                    if (bit_cnt == 6'd7) begin
                                        q_c     <= cmd_next;
                                        bit_cnt <= '0;
                                        if (cmd_next == 8'h01) begin
                                            tx       <= {STATUS, 16'h0};
                                            mem_addr <= '0;
                                            state    <= MEM;
                                        end else begin
                                            tx    <= rd_word;
                                            state <= CFG;
                                        end
                                    end
                                end

                                CFG: begin
                                    if (bit_cnt == 6'd32) begin
                                        rx <= {rx[29:0], 1'b0};
                                    end else begin
                                        rx      <= rx_word_next[30:0];
                                        bit_cnt <= bit_cnt + 6'd1;
                                    end
                                    if (bit_cnt == 6'd31 && wr_en) begin
                                        case (q_c[6:0])
                                            7'd0:    adc_cfg_out   <= rx_word_next;
                                            7'd2:    dds_a_cfg_out <= rx_word_next;
                                            7'd3:    dds_b_cfg_out <= rx_word_next;
                                            default: ;
                                        endcase
                                    end
                                end

                                MEM: begin
                                    // mem_data has been stable since mem_addr last moved
                                    if (bit_cnt == 6'd15) begin
                                        bit_cnt  <= '0;
                                        tx       <= {mem_data, 16'h0};
                                        addr_inc <= 1'b1;
                                    end else begin
                                        bit_cnt <= bit_cnt + 6'd1;
                                    end
                                end

                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_module.sv
// Directed bench for spi_slave_module: register writes/reads, memory stream,
// abort, ignored writes, over-long frames and reset mid-frame.
module tb_spi_slave_module;

    logic        clk = 1'b0;
    logic        reset;
    logic        sck;
    logic        mosi;
    logic        ncs;
    logic        miso;
    logic [7:0]  q_c;
    logic [31:0] adc_cfg;
    logic [31:0] dds_a_cfg;
    logic [31:0] dds_b_cfg;
    logic [15:0] mem_data;
    logic [11:0] mem_addr;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Buffer model: content at address a is {4'hE, a}, available one clk after the address.
    always_ff @(posedge clk) mem_data <= {4'hE, mem_addr};

    spi_slave_module #(
        .ID(8'hA5),
        .STATUS(16'h5A01),
        .ADDR_W(12)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sck_spi(sck),
        .mosi_spi(mosi),
        .ncs_spi(ncs),
        .miso_spi(miso),
        .q_c(q_c),
        .adc_cfg_out(adc_cfg),
        .dds_a_cfg_out(dds_a_cfg),
        .dds_b_cfg_out(dds_b_cfg),
        .mem_data(mem_data),
        .mem_addr(mem_addr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        repeat (8) @(negedge clk);
        r = miso;
        sck = 1'b1;
        repeat (8) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic spi_frame(input int nbits, input logic [255:0] tx, output logic [255:0] rx);
        logic r;
        rx  = '0;
        ncs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx = {rx[254:0], r};
        end
        repeat (8) @(negedge clk);
        ncs  = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic cfg_frame(input logic [7:0] cmd, input logic [31:0] data,
                             output logic [7:0] id_ret, output logic [31:0] data_ret);
        logic [255:0] rx;
        spi_frame(40, {216'b0, cmd, data}, rx);
        id_ret   = rx[39:32];
        data_ret = rx[31:0];
    endtask

    initial begin
        logic [255:0] rx;
        logic [7:0]   id_r;
        logic [31:0]  d_r;
        logic         r;

        reset = 1'b1;
        sck   = 1'b0;
        mosi  = 1'b0;
        ncs   = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_q_c", q_c, 0);
        check("rst_adc", adc_cfg, 0);
        check("rst_dds_a", dds_a_cfg, 0);
        check("rst_dds_b", dds_b_cfg, 0);
        check("rst_addr", mem_addr, 0);

        cfg_frame(8'h80, 32'h01234567, id_r, d_r);
        check("w80_id", id_r, 8'hA5);
        check("w80_old", d_r, 32'h0);
        check("w80_adc", adc_cfg, 32'h01234567);
        cfg_frame(8'h82, 32'h00112233, id_r, d_r);
        check("w82_id", id_r, 8'hA5);
        check("w82_old", d_r, 32'h0);
        check("w82_dds_a", dds_a_cfg, 32'h00112233);
        cfg_frame(8'h83, 32'hBABEFDCA, id_r, d_r);
        check("w83_id", id_r, 8'hA5);
        check("w83_old", d_r, 32'h0);
        check("w83_dds_b", dds_b_cfg, 32'hBABEFDCA);
        check("w83_q_c", q_c, 8'h83);
        check("miso_idle", miso, 0);

        cfg_frame(8'h00, 32'h0, id_r, d_r);
        check("r00_id", id_r, 8'hA5);
        check("r00_data", d_r, 32'h01234567);
        cfg_frame(8'h02, 32'h0, id_r, d_r);
        check("r02_data", d_r, 32'h00112233);
        cfg_frame(8'h03, 32'h0, id_r, d_r);
        check("r03_data", d_r, 32'hBABEFDCA);
        check("rd_adc", adc_cfg, 32'h01234567);
        check("rd_dds_a", dds_a_cfg, 32'h00112233);
        check("rd_dds_b", dds_b_cfg, 32'hBABEFDCA);

        // 8 command bits + 11 words (STATUS and buffer words 0..9)
        spi_frame(184, {8'h01, 248'b0} >> 72, rx);
        check("mem_id", rx[183:176], 8'hA5);
        check("mem_status", rx[175:160], 16'h5A01);
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("mem_w%0d", k), rx[175 - 16 * k -: 16], 16'hE000 + 16'(k - 1));
        end
        check("mem_q_c", q_c, 8'h01);
        check("mem_addr_end", mem_addr, 12'd11);

        spi_frame(28, {228'b0, 8'h80, 20'hFFFFF}, rx);
        check("abort_adc", adc_cfg, 32'h01234567);
        cfg_frame(8'h00, 32'h0, id_r, d_r);
        check("abort_next_id", id_r, 8'hA5);
        check("abort_next_data", d_r, 32'h01234567);

        cfg_frame(8'h81, 32'hFFFFFFFF, id_r, d_r);
        check("w81_ret", d_r, 32'h0);
        cfg_frame(8'h84, 32'hFFFFFFFF, id_r, d_r);
        check("w84_q_c", q_c, 8'h84);
        check("ign_adc", adc_cfg, 32'h01234567);
        check("ign_dds_a", dds_a_cfg, 32'h00112233);
        check("ign_dds_b", dds_b_cfg, 32'hBABEFDCA);

        spi_frame(48, {208'b0, 8'h82, 32'h00112233, 8'hFF}, rx);
        check("long_old", rx[39:8], 32'h00112233);
        check("long_tail", rx[7:0], 8'h00);
        check("long_dds_a", dds_a_cfg, 32'h00112233);

        ncs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 12; i++) spi_bit(i[0], r);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_miso", miso, 0);
        check("mid_rst_adc", adc_cfg, 0);
        check("mid_rst_dds_a", dds_a_cfg, 0);
        check("mid_rst_dds_b", dds_b_cfg, 0);
        check("mid_rst_q_c", q_c, 0);
        for (int i = 0; i < 12; i++) spi_bit(1'b1, r);
        check("mid_rst_ignored_miso", miso, 0);
        check("mid_rst_ignored_q_c", q_c, 0);
        ncs = 1'b1;
        repeat (12) @(negedge clk);
        cfg_frame(8'h80, 32'h55AA55AA, id_r, d_r);
        check("post_rst_id", id_r, 8'hA5);
        check("post_rst_old", d_r, 32'h0);
        check("post_rst_adc", adc_cfg, 32'h55AA55AA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
